// File: rtl/step_pos_decoder.sv
// rtl/step_pos_decoder.sv - two-axis step/dir position decoder; STEP_POS_LIMIT_EN compiles in soft limits
module step_pos_decoder #(
    parameter int          SYNC_STAGES  = 2,
    parameter int          MIN_PERIOD   = 100,
    parameter int          IDLE_TIMEOUT = 1000000,
    parameter logic [31:0] X_MAX        = 32'd20000,
    parameter logic [31:0] Y_MAX        = 32'd20000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        step_x,
    input  logic        step_y,
    input  logic        dir_x,
    input  logic        dir_y,
    input  logic        clear_x,
    input  logic        clear_y,
    output logic [31:0] pos_x,
    output logic [31:0] pos_y,
    output logic        moving_x,
    output logic        moving_y,
    output logic        overspeed_x,
    output logic        overspeed_y,
    output logic        limit_x,
    output logic        limit_y
);
    typedef enum logic {IDLE = 1'b0, MOVING = 1'b1} state_t;

    localparam logic [31:0] MIN_GAP   = 32'(MIN_PERIOD - 1);
    localparam logic [31:0] IDLE_GAP  = 32'(IDLE_TIMEOUT - 1);
    localparam logic [2:0]  FILL_DONE = 3'(SYNC_STAGES);

`ifdef STEP_POS_LIMIT_EN
    localparam logic [1:0][31:0] POS_MAX = {Y_MAX, X_MAX};
`else
    logic unused_pos_max;
    assign unused_pos_max = ^{X_MAX, Y_MAX};
`endif

    // Index 0 is the X axis, index 1 the Y axis.
    logic [1:0]                  step_in, dir_in, clear_in;
    logic [1:0][SYNC_STAGES-1:0] step_sync_q, step_sync_d;
    logic [1:0][SYNC_STAGES-1:0] dir_sync_q, dir_sync_d;
    logic [1:0]                  step_prev_q, step_prev_d;
    logic [1:0][2:0]             fill_q, fill_d;
    logic [1:0]                  armed_q, armed_d;
    logic [1:0]                  seen_q, seen_d;
    logic [1:0][31:0]            gap_q, gap_d;
    logic [1:0][31:0]            pos_q, pos_d;
    logic [1:0]                  overspeed_q, overspeed_d;
    logic [1:0]                  limit_q, limit_d;
    state_t                      state_q [2];
    state_t                      state_d [2];
    logic [1:0]                  step_level, step_dir, step_edge;

    assign step_in  = {step_y, step_x};
    assign dir_in   = {dir_y, dir_x};
    assign clear_in = {clear_y, clear_x};

    always_comb begin
        for (int a = 0; a < 2; a++) begin
            step_sync_d[a] = {step_sync_q[a][SYNC_STAGES-2:0], step_in[a]};
            dir_sync_d[a]  = {dir_sync_q[a][SYNC_STAGES-2:0], dir_in[a]};
            step_level[a]  = step_sync_q[a][SYNC_STAGES-1];
            step_dir[a]    = dir_sync_q[a][SYNC_STAGES-1];
            step_prev_d[a] = step_level[a];
            fill_d[a]      = (fill_q[a] == FILL_DONE) ? fill_q[a] : fill_q[a] + 3'd1;
            // A level held high across reset must be seen low before any edge counts.
            armed_d[a]     = armed_q[a] | ((fill_q[a] == FILL_DONE) & ~step_level[a]);
            step_edge[a]   = armed_q[a] & step_level[a] & ~step_prev_q[a];

            gap_d[a]       = gap_q[a];
            pos_d[a]       = pos_q[a];
            seen_d[a]      = seen_q[a];
            overspeed_d[a] = overspeed_q[a];
            limit_d[a]     = limit_q[a];
            state_d[a]     = state_q[a];

            if (clear_in[a]) begin
                gap_d[a]       = 32'd0;
                pos_d[a]       = 32'd0;
                seen_d[a]      = 1'b0;
                overspeed_d[a] = 1'b0;
                state_d[a]     = IDLE;
`ifdef STEP_POS_LIMIT_EN
                limit_d[a]     = 1'b1;
`endif
            end else if (step_edge[a]) begin
                gap_d[a]   = 32'd0;
                seen_d[a]  = 1'b1;
                state_d[a] = MOVING;
                if (seen_q[a] && (gap_q[a] < MIN_GAP)) begin
                    overspeed_d[a] = 1'b1;
                end
`ifdef STEP_POS_LIMIT_EN
                if (!step_dir[a]) begin
                    if (pos_q[a] < POS_MAX[a]) pos_d[a] = pos_q[a] + 32'd1;
                end else if (pos_q[a] != 32'd0) begin
                    pos_d[a] = pos_q[a] - 32'd1;
                end
                limit_d[a] = (pos_d[a] == 32'd0) || (pos_d[a] == POS_MAX[a]);
`else
                pos_d[a] = step_dir[a] ? pos_q[a] - 32'd1 : pos_q[a] + 32'd1;
`endif
            end else begin
                if (gap_q[a] != 32'hFFFF_FFFF) gap_d[a] = gap_q[a] + 32'd1;
                if ((state_q[a] == MOVING) && (gap_q[a] == IDLE_GAP)) state_d[a] = IDLE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            step_sync_q <= '0;
            dir_sync_q  <= '0;
            step_prev_q <= '0;
            fill_q      <= '0;
            armed_q     <= '0;
            seen_q      <= '0;
            gap_q       <= '0;
            pos_q       <= '0;
            overspeed_q <= '0;
            limit_q     <= '0;
            state_q     <= '{IDLE, IDLE};
        end else begin
            step_sync_q <= step_sync_d;
            dir_sync_q  <= dir_sync_d;
            step_prev_q <= step_prev_d;
            fill_q      <= fill_d;
            armed_q     <= armed_d;
            seen_q      <= seen_d;
            gap_q       <= gap_d;
            pos_q       <= pos_d;
            overspeed_q <= overspeed_d;
            limit_q     <= limit_d;
            state_q     <= state_d;
        end
    end

    assign pos_x       = pos_q[0];
    assign pos_y       = pos_q[1];
    assign moving_x    = (state_q[0] == MOVING);
    assign moving_y    = (state_q[1] == MOVING);
    assign overspeed_x = overspeed_q[0];
    assign overspeed_y = overspeed_q[1];
    assign limit_x     = limit_q[0];
    assign limit_y     = limit_q[1];
endmodule

// File: tb/tb_step_pos_decoder.sv
// tb/tb_step_pos_decoder.sv - self-checking bench for step_pos_decoder
module tb_step_pos_decoder;
    localparam int          SYNC    = 2;
    localparam int          MINP    = 100;
    localparam int          IDLE_TO = 10;
    localparam logic [31:0] XMAX    = 32'd12;
    localparam logic [31:0] YMAX    = 32'd20000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        step_x = 1'b0, step_y = 1'b0, dir_x = 1'b0, dir_y = 1'b0;
    logic        clear_x = 1'b0, clear_y = 1'b0;
    logic [31:0] pos_x, pos_y;
    logic        moving_x, moving_y, overspeed_x, overspeed_y, limit_x, limit_y;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] m_pos [2];
    int          m_acc [2];
    bit          m_ovs [2];
    bit          m_limv [2];
    logic [31:0] m_max [2];

    step_pos_decoder #(
        .SYNC_STAGES(SYNC), .MIN_PERIOD(MINP), .IDLE_TIMEOUT(IDLE_TO),
        .X_MAX(XMAX), .Y_MAX(YMAX)
    ) dut (
        .clock(clock), .reset(reset),
        .step_x(step_x), .step_y(step_y), .dir_x(dir_x), .dir_y(dir_y),
        .clear_x(clear_x), .clear_y(clear_y),
        .pos_x(pos_x), .pos_y(pos_y),
        .moving_x(moving_x), .moving_y(moving_y),
        .overspeed_x(overspeed_x), .overspeed_y(overspeed_y),
        .limit_x(limit_x), .limit_y(limit_y)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 2; a++) begin
            m_pos[a] = 32'd0; m_acc[a] = -1; m_ovs[a] = 1'b0; m_limv[a] = 1'b0;
        end
    endtask

    task automatic model_clear(input int ax);
        m_pos[ax] = 32'd0; m_acc[ax] = -1; m_ovs[ax] = 1'b0; m_limv[ax] = 1'b1;
    endtask

    // Position bookkeeping per accepted step, in cycle numbers of the accepting edge.
    task automatic model_step(input int ax, input bit d, input int rise);
        int acc;
        acc = rise + SYNC;
        if (m_acc[ax] >= 0 && (acc - m_acc[ax]) < MINP) m_ovs[ax] = 1'b1;
        m_acc[ax]  = acc;
        m_limv[ax] = 1'b1;
`ifdef STEP_POS_LIMIT_EN
        if (!d && m_pos[ax] < m_max[ax]) m_pos[ax] = m_pos[ax] + 32'd1;
        else if (d && m_pos[ax] != 32'd0) m_pos[ax] = m_pos[ax] - 32'd1;
`else
        m_pos[ax] = d ? m_pos[ax] - 32'd1 : m_pos[ax] + 32'd1;
`endif
    endtask

    function automatic bit exp_moving(input int ax);
        return (m_acc[ax] >= 0) && ((cyc - m_acc[ax]) < IDLE_TO);
    endfunction

    function automatic bit exp_limit(input int ax);
`ifdef STEP_POS_LIMIT_EN
        return m_limv[ax] && (m_pos[ax] == 32'd0 || m_pos[ax] == m_max[ax]);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_model(input string tag);
        chk({tag, " pos_x"}, pos_x, m_pos[0]);
        chk({tag, " pos_y"}, pos_y, m_pos[1]);
        chk({tag, " moving_x"}, {31'd0, moving_x}, {31'd0, exp_moving(0)});
        chk({tag, " moving_y"}, {31'd0, moving_y}, {31'd0, exp_moving(1)});
        chk({tag, " overspeed_x"}, {31'd0, overspeed_x}, {31'd0, m_ovs[0]});
        chk({tag, " overspeed_y"}, {31'd0, overspeed_y}, {31'd0, m_ovs[1]});
        chk({tag, " limit_x"}, {31'd0, limit_x}, {31'd0, exp_limit(0)});
        chk({tag, " limit_y"}, {31'd0, limit_y}, {31'd0, exp_limit(1)});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Raw rise-to-rise spacing of d cycles when following a width-1 pulse.
    task automatic space_to(input int d);
        idle(d - SYNC - 2);
    endtask

    task automatic pulse(input bit px, input bit py, input bit dx, input bit dy, input int w);
        if (px) begin dir_x = dx; step_x = 1'b1; model_step(0, dx, cyc + 1); end
        if (py) begin dir_y = dy; step_y = 1'b1; model_step(1, dy, cyc + 1); end
        idle(w);
        step_x = 1'b0;
        step_y = 1'b0;
        idle(SYNC + 1);
    endtask

    task automatic do_clear(input bit cx, input bit cy);
        clear_x = cx;
        clear_y = cy;
        @(negedge clock);
        clear_x = 1'b0;
        clear_y = 1'b0;
        if (cx) model_clear(0);
        if (cy) model_clear(1);
    endtask

    initial begin
        int cnt;
        bit px, py;
        m_max[0] = XMAX;
        m_max[1] = YMAX;
        model_reset();

        // Reset state
        idle(3);
        chk("rst pos_x", pos_x, 32'd0);
        chk("rst pos_y", pos_y, 32'd0);
        chk("rst flags", {26'd0, moving_x, moving_y, overspeed_x, overspeed_y, limit_x, limit_y}, 32'd0);
        reset = 1'b0;
        idle(5);
        check_model("post_rst");

        // First-step latency: update lands SYNC edges after raw step is first sampled
        dir_x = 1'b0;
        step_x = 1'b1;
        model_step(0, 1'b0, cyc + 1);
        for (int i = 0; i < SYNC; i++) begin
            @(negedge clock);
            chk("latency hold pos_x", pos_x, 32'd0);
        end
        @(negedge clock);
        chk("latency update pos_x", pos_x, 32'd1);
        step_x = 1'b0;
        idle(200);

        // Five increments at 200-cycle spacing
        for (int i = 0; i < 4; i++) begin
            pulse(1'b1, 1'b0, 1'b0, 1'b0, 1);
            if (i < 3) space_to(200);
        end
        chk("five steps pos_x", pos_x, 32'd5);
        chk("five steps moving_x", {31'd0, moving_x}, 32'd1);
        chk("five steps pos_y", pos_y, 32'd0);
        chk("five steps overspeed_x", {31'd0, overspeed_x}, 32'd0);
        check_model("five_steps");

        // Three decrements on Y from zero
        for (int i = 0; i < 3; i++) begin
            pulse(1'b0, 1'b1, 1'b0, 1'b1, 1);
            space_to(200);
        end
`ifdef STEP_POS_LIMIT_EN
        chk("y down pos_y", pos_y, 32'd0);
        chk("y down limit_y", {31'd0, limit_y}, 32'd1);
`else
        chk("y down pos_y", pos_y, 32'hFFFF_FFFD);
        chk("y down limit_y", {31'd0, limit_y}, 32'd0);
`endif
        check_model("y_down");

        // Two steps 50 cycles apart raise sticky overspeed until cleared
        do_clear(1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1);
        space_to(50);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1);
        chk("fast pair pos_x", pos_x, 32'd2);
        chk("fast pair overspeed_x", {31'd0, overspeed_x}, 32'd1);
        idle(150);
        chk("overspeed sticky", {31'd0, overspeed_x}, 32'd1);
        do_clear(1'b1, 1'b0);
        chk("clear pos_x", pos_x, 32'd0);
        chk("clear overspeed_x", {31'd0, overspeed_x}, 32'd0);
        check_model("after_clear");

        // Spacing boundary: exactly MIN_PERIOD is legal, one less is not
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1);
        space_to(MINP);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1);
        chk("spacing 100 overspeed_x", {31'd0, overspeed_x}, 32'd0);
        space_to(MINP - 1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1);
        chk("spacing 99 overspeed_x", {31'd0, overspeed_x}, 32'd1);
        do_clear(1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1);
        chk("first after clear overspeed_x", {31'd0, overspeed_x}, 32'd0);
        check_model("boundary");

        // Clear in the detect cycle drops that step
        idle(120);
        step_x = 1'b1;
        dir_x = 1'b0;
        @(negedge clock);
        step_x = 1'b0;
        @(negedge clock);
        clear_x = 1'b1;
        @(negedge clock);
        clear_x = 1'b0;
        model_clear(0);
        chk("clear wins pos_x", pos_x, 32'd0);
        idle(5);
        check_model("clear_wins");

        // Idle timeout: moving for exactly IDLE_TIMEOUT cycles after one step
        idle(20);
        step_x = 1'b1;
        model_step(0, 1'b0, cyc + 1);
        @(negedge clock);
        step_x = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (moving_x) cnt++;
        end
        chk("timeout moving cycles", 32'(cnt), 32'd10);
        chk("timeout moving_x low", {31'd0, moving_x}, 32'd0);

        // Reset one cycle after raw step rises; level held across deassert is ignored
        do_clear(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            pulse(1'b1, 1'b0, 1'b0, 1'b0, 1);
            space_to(110);
        end
        chk("seven steps pos_x", pos_x, 32'd7);
        step_x = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        model_reset();
        chk("reset in flight pos_x", pos_x, 32'd0);
        idle(20);
        chk("held through reset pos_x", pos_x, 32'd0);
        check_model("held_high");
        step_x = 1'b0;
        idle(5);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1);
        chk("rearmed pos_x", pos_x, 32'd1);

        // Randomized traffic on both axes against the model
        for (int i = 0; i < 40; i++) begin
            px = 1'($urandom_range(0, 1));
            py = 1'($urandom_range(0, 1));
            if (!px && !py) px = 1'b1;
            pulse(px, py, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 4));
            check_model($sformatf("rand%0d", i));
            idle($urandom_range(0, 140));
            if ($urandom_range(0, 7) == 0) begin
                do_clear(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                check_model($sformatf("rand_clear%0d", i));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/step_pos_decoder.md
STEP_POS_DECODER -- requirements
Module: step_pos_decoder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on step/dir inputs (legal values 2..4).
REQ-002 SHALL have parameter MIN_PERIOD, default 100: minimum legal clock cycles between accepted step edges on one axis.
REQ-003 SHALL have parameter IDLE_TIMEOUT, default 1000000: cycles without a step before the axis returns to IDLE.
REQ-004 SHALL have parameters X_MAX and Y_MAX, default 32'd20000: soft-limit ceilings, used only under REQ-031.
REQ-005 SHALL have port clock, input, 1: the single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have ports step_x and step_y, input, 1 each: asynchronous step pulses, one step per rising edge.
REQ-008 SHALL have ports dir_x and dir_y, input, 1 each: asynchronous direction (1 = decrement, 0 = increment).
REQ-009 SHALL have ports clear_x and clear_y, input, 1 each: synchronous zero request per axis.
REQ-010 SHALL have ports pos_x and pos_y, output, 32 each: registered two's-complement step count per axis.
REQ-011 SHALL have ports moving_x and moving_y, output, 1 each: axis state is MOVING.
REQ-012 SHALL have ports overspeed_x and overspeed_y, output, 1 each: sticky flag for a step closer than MIN_PERIOD.
REQ-013 SHALL have ports limit_x and limit_y, output, 1 each: axis is at a soft limit.

Function
REQ-014 SHALL pass each step and dir input through a SYNC_STAGES-deep flop chain before any use.
REQ-015 SHALL detect a step as synchronized step high while its registered previous value is low; one count per rising edge regardless of pulse width.
REQ-016 SHALL sample direction from the synchronized dir in the same cycle the edge is detected.
REQ-017 SHALL update pos on the rising edge SYNC_STAGES edges after the edge that first samples raw step high (default: edge k+2).
REQ-018 SHALL add 1 for dir=0 and subtract 1 for dir=1; without REQ-031, 32-bit wrap (0x7FFFFFFF+1 -> 0x80000000, 0-1 -> 0xFFFFFFFF).
REQ-019 SHALL keep per axis a 32-bit gap counter: cleared on each accepted step, otherwise increments and saturates at all-ones.
REQ-020 SHALL count a step arriving with gap counter < MIN_PERIOD-1 normally and also set overspeed for that axis; the first step after reset or clear never sets overspeed.
REQ-021 SHALL implement per-axis FSM IDLE/MOVING: IDLE->MOVING on accepted step; MOVING->IDLE when gap counter reaches IDLE_TIMEOUT-1 with no step; moving = (state==MOVING), registered.
REQ-022 SHALL on clear: pos=0, overspeed=0, gap counter=0, state=IDLE, on the next edge; a step detected in the same cycle is dropped (clear wins).
REQ-023 SHALL keep X and Y fully independent; simultaneous steps on both axes each count.
REQ-024 SHALL hold all outputs stable in cycles with no step and no clear.

Reset
REQ-025 SHALL, with reset high at a rising edge, clear all synchronizer and edge flops to 0.
REQ-026 SHALL on reset set pos_x=pos_y=0, moving=0, overspeed=0, limit=0, gap counters=0, FSMs=IDLE.
REQ-027 SHALL give reset priority over clear and step; a step in flight when reset asserts is discarded.
REQ-028 SHALL not count a step whose synchronized level is already high when reset deasserts until it goes low and high again.

Configuration
REQ-029 SHALL use macro STEP_POS_LIMIT_EN to compile soft limits in or out.
REQ-030 SHALL, without STEP_POS_LIMIT_EN, tie limit_x and limit_y to 0 and wrap per REQ-018.
REQ-031 SHALL, with STEP_POS_LIMIT_EN, saturate pos_x to [0, X_MAX] and pos_y to [0, Y_MAX]: a step beyond a bound leaves pos unchanged but still updates gap counter/FSM/overspeed; limit = (pos==0 || pos==MAX), registered.

Verification
REQ-032 SHALL cover: reset, 5 step_x pulses (dir_x=0, 200-cycle spacing) -> pos_x=5, pos_x first changes at edge k+2, moving_x=1, pos_y=0.
REQ-033 SHALL cover: 3 steps dir_y=1 from 0, macro off -> pos_y=0xFFFFFFFD, limit_y=0; macro on -> pos_y=0, limit_y=1.
REQ-034 SHALL cover: two step_x edges 50 cycles apart (MIN_PERIOD=100) -> pos_x=2, overspeed_x=1 until clear_x pulse -> pos_x=0, overspeed_x=0.
REQ-035 SHALL cover: clear_x asserted in the same cycle an edge is detected -> pos_x=0 next edge, step not counted.
REQ-036 SHALL cover: IDLE_TIMEOUT=10, one step then silence -> moving_x=1 for exactly 10 cycles after the accepted step, then 0.
REQ-037 SHALL cover: reset asserted 1 cycle after raw step_x rises with pos_x=7 -> pos_x=0, no count; step held high through deassert does not count.
